// File: rtl/timer_pkg.sv
// Shared types and address map for the multi-channel system-bus timer.
//   timer_mode_e : channel operating mode (OFF / NTIMES / FOREVER)
//   chan_bus_t   : write/read payload broadcast from the top to every channel
//   ADDR_* / OFS_* : global register addresses and per-channel field offsets
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned OFS_W  = 5;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_NTIMES  = 2'd1,
    MODE_FOREVER = 2'd2
  } timer_mode_e;

  // Global registers
  localparam logic [31:0] ADDR_CNT_LO     = 32'h0000_0000;
  localparam logic [31:0] ADDR_CNT_HI     = 32'h0000_0004;
  localparam logic [31:0] ADDR_PRESCALE   = 32'h0000_0008;
  localparam logic [31:0] ADDR_IRQ_STATUS = 32'h0000_000C;
  localparam logic [31:0] ADDR_IRQ_ENABLE = 32'h0000_0010;
  localparam logic [31:0] ADDR_SOFT_RST   = 32'h0000_0024;

  // Channel window
  localparam logic [31:0] CH_BASE   = 32'h0000_0040;
  localparam logic [31:0] CH_STRIDE = 32'h0000_0020;

  // Field offsets inside one channel window
  localparam logic [OFS_W-1:0] OFS_DELAY_LO = 5'h00;
  localparam logic [OFS_W-1:0] OFS_DELAY_HI = 5'h04;
  localparam logic [OFS_W-1:0] OFS_MODE     = 5'h08;
  localparam logic [OFS_W-1:0] OFS_REPEAT   = 5'h0C;
  localparam logic [OFS_W-1:0] OFS_REMAIN   = 5'h10;

  typedef struct packed {
    logic              we;
    logic [OFS_W-1:0]  ofs;
    logic [DATA_W-1:0] data;
  } chan_bus_t;

  // A zero delay behaves as one tick so an armed channel never fires every cycle at rest.
  function automatic logic [CNT_W-1:0] fire_threshold(input logic [CNT_W-1:0] delay);
    return (delay == '0) ? CNT_W'(1) : delay;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare channel: holds delay/mode/repeat/remaining/start and raises a
// fire pulse when the elapsed ticks since start reach the delay.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous soft reset of all channel state
//   sel        : bus address falls in this channel's window
//   bus        : broadcast write strobe, field offset and data
//   counter    : registered system counter
//   fire_c     : combinational fire indication from registered state
//   rdata_c    : combinational read mux of this channel's fields
module timer_channel
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sel,
  input  chan_bus_t         bus,
  input  logic [CNT_W-1:0]  counter,
  output logic              fire_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [CNT_W-1:0]  delay;
  logic [CNT_W-1:0]  start;
  logic [DATA_W-1:0] rep;
  logic [DATA_W-1:0] remaining;
  timer_mode_e       mode;

  logic wr;
  logic mode_wr;
  logic arm;

  assign wr      = sel & bus.we;
  // Encodings above FOREVER are dropped entirely.
  assign mode_wr = wr && (bus.ofs == OFS_MODE) && (bus.data <= DATA_W'(2));
  assign arm     = mode_wr && (bus.data[1:0] != 2'd0);

  // Modular subtraction keeps the comparison correct across counter wrap.
  assign fire_c = (mode != MODE_OFF) && ((counter - start) >= fire_threshold(delay));

  // Channel state; a bus mode write takes priority over a fire in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay     <= '0;
      start     <= '0;
      rep       <= '0;
      remaining <= '0;
      mode      <= MODE_OFF;
    end else if (clear) begin
      delay     <= '0;
      start     <= '0;
      rep       <= '0;
      remaining <= '0;
      mode      <= MODE_OFF;
    end else begin
      if (wr && (bus.ofs == OFS_DELAY_LO)) delay[31:0]  <= bus.data;
      if (wr && (bus.ofs == OFS_DELAY_HI)) delay[63:32] <= bus.data;
      if (wr && (bus.ofs == OFS_REPEAT))   rep          <= bus.data;
      if (mode_wr) begin
        mode <= timer_mode_e'(bus.data[1:0]);
        if (arm) begin
          start     <= counter;
          remaining <= (rep == '0) ? DATA_W'(1) : rep;
        end
      end else if (fire_c) begin
        start <= counter;
        if (mode == MODE_NTIMES) begin
          if (remaining > DATA_W'(1)) begin
            remaining <= remaining - DATA_W'(1);
          end else begin
            remaining <= '0;
            mode      <= MODE_OFF;
          end
        end
      end
    end
  end

  // Field read mux; unmapped offsets inside the window read 0.
  always_comb begin
    rdata_c = '0;
    case (bus.ofs)
      OFS_DELAY_LO: rdata_c = delay[31:0];
      OFS_DELAY_HI: rdata_c = delay[63:32];
      OFS_MODE:     rdata_c = DATA_W'(mode);
      OFS_REPEAT:   rdata_c = rep;
      OFS_REMAIN:   rdata_c = remaining;
      default:      rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/multi_timer_sb_ctrl.sv
// Multi-channel system-bus timer: prescaled 64-bit counter, CHANNELS compare
// channels, sticky W1C status masked by enable into one level interrupt.
//   clk_i, rst_ni        : clock, async active-low reset
//   req_i, write_enable_i: bus request and direction (1 = write)
//   addr_i, write_data_i : word-aligned byte address and write data
//   read_data_o          : combinational read data
//   ready_o              : always equal to req_i (no wait states)
//   interrupt_request_o  : |(irq_status & irq_enable)
module multi_timer_sb_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        interrupt_request_o
);

  logic [CNT_W-1:0]    counter;
  logic [PRESC_W-1:0]  divider;
  logic [PRESC_W-1:0]  prescale;
  logic [CHANNELS-1:0] irq_status;
  logic [CHANNELS-1:0] irq_enable;
  logic [CHANNELS-1:0] fire;
  logic [CHANNELS-1:0] ch_sel;
  logic [CHANNELS-1:0] w1c_mask;
  logic [DATA_W-1:0]   ch_rdata [CHANNELS];

  logic      wr;
  logic      soft_rst;
  logic      tick;
  chan_bus_t ch_bus;

  assign ready_o  = req_i;
  assign wr       = req_i & write_enable_i;
  assign soft_rst = wr && (addr_i == ADDR_SOFT_RST);
  // >= rather than == so lowering prescale below the running divider still wraps.
  assign tick     = (divider >= prescale);
  assign w1c_mask = (wr && (addr_i == ADDR_IRQ_STATUS)) ? write_data_i[CHANNELS-1:0] : '0;
  assign ch_bus   = '{we: wr, ofs: addr_i[OFS_W-1:0], data: write_data_i};

  // Channel instances and their window decode
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    localparam logic [31:0] BASE = CH_BASE + CH_STRIDE * 32'(n);
    assign ch_sel[n] = (addr_i[31:OFS_W] == BASE[31:OFS_W]);

    timer_channel u_ch (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .clear   (soft_rst),
      .sel     (ch_sel[n]),
      .bus     (ch_bus),
      .counter (counter),
      .fire_c  (fire[n]),
      .rdata_c (ch_rdata[n])
    );
  end

  // Prescaler and system counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      counter <= '0;
      divider <= '0;
    end else if (soft_rst) begin
      counter <= '0;
      divider <= '0;
    end else if (tick) begin
      counter <= counter + CNT_W'(1);
      divider <= '0;
    end else begin
      divider <= divider + PRESC_W'(1);
    end
  end

  // Global registers; a fire wins over a W1C of the same bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale   <= '0;
      irq_status <= '0;
      irq_enable <= '0;
    end else if (soft_rst) begin
      prescale   <= '0;
      irq_status <= '0;
      irq_enable <= '0;
    end else begin
      if (wr && (addr_i == ADDR_PRESCALE))   prescale   <= write_data_i[PRESC_W-1:0];
      if (wr && (addr_i == ADDR_IRQ_ENABLE)) irq_enable <= write_data_i[CHANNELS-1:0];
      irq_status <= (irq_status & ~w1c_mask) | fire;
    end
  end

  // Read mux
  always_comb begin
    read_data_o = '0;
    if (req_i) begin
      case (addr_i)
        ADDR_CNT_LO:     read_data_o = counter[31:0];
        ADDR_CNT_HI:     read_data_o = counter[63:32];
        ADDR_PRESCALE:   read_data_o = DATA_W'(prescale);
        ADDR_IRQ_STATUS: read_data_o = DATA_W'(irq_status);
        ADDR_IRQ_ENABLE: read_data_o = DATA_W'(irq_enable);
        default: begin
          for (int n = 0; n < CHANNELS; n++) begin
            if (ch_sel[n]) read_data_o = read_data_o | ch_rdata[n];
          end
        end
      endcase
    end
  end

  assign interrupt_request_o = |(irq_status & irq_enable);

endmodule

// File: doc/multi_timer_sb_ctrl.md
# multi_timer_sb_ctrl

Multi-channel system-bus timer peripheral. It has one free-running 64-bit system counter with a programmable prescaler, and `CHANNELS` independent compare channels. Each channel runs in OFF, NTIMES or FOREVER mode. Channel events latch into a sticky, write-1-to-clear status register, which is masked by an enable register and drives one level interrupt line to the interrupt controller. The block sits on the core's system bus in the same slot as the single-channel timer controller.

## Interface
- `CHANNELS`, default 4: number of compare channels, legal range 1..8.
- `PRESC_W`, default 16: prescaler register width, legal range 1..32.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `req_i` input 1: bus request.
- `write_enable_i` input 1: 1 selects write, 0 selects read.
- `addr_i` input 32: byte address, word aligned.
- `write_data_i` input 32: write data.
- `read_data_o` output 32: combinational read data.
- `ready_o` output 1: equals `req_i`; there are no wait states.
- `interrupt_request_o` output 1: level output, equal to |(irq_status & irq_enable).

## Operation
- Register map, global:
  - 0x00/0x04: counter lo/hi, read-only.
  - 0x08: prescale, R/W, `PRESC_W` bits, zero-extended on read.
  - 0x0C: irq_status, write 1 to clear.
  - 0x10: irq_enable, R/W.
  - 0x24: soft reset; a write of any data clears all state.
  - irq_status and irq_enable use bits [CHANNELS-1:0]; upper bits read 0 and ignore writes.
- Register map, channel n at base 0x40+0x20·n:
  - +0x00/+0x04: delay lo/hi.
  - +0x08: mode.
  - +0x0C: repeat.
  - +0x10: remaining, read-only.
- Reads of unmapped addresses return 0. Writes to unmapped or read-only addresses are ignored.
- Prescaler: a divider counter runs from 0 to prescale. The system counter increments by 1 in the cycle the divider wraps. With prescale=P, one tick occurs every P+1 clocks; P=0 ticks every clock.
- Mode encoding: OFF=0, NTIMES=1, FOREVER=2.
  - A mode write of 3 is ignored.
  - Writing NTIMES or FOREVER (re)arms the channel:
    - start ← counter.
    - remaining ← repeat, with repeat=0 treated as 1.
  - Writing OFF disarms the channel; remaining is kept.
- Fire condition: the channel is armed and (counter − start) mod 2^64 ≥ max(delay,1). Delay 0 behaves as 1, so a channel never fires continuously.
- On fire:
  - start ← counter.
  - irq_status[n] ← 1.
  - In NTIMES mode: if remaining > 1, decrement it; otherwise set remaining ← 0 and mode ← OFF.
  - In FOREVER mode, remaining is not modified.
- Delay is compared live: a write while armed takes effect on the next cycle's comparison.
- Simultaneous events:
  - Fire and W1C of the same bit in one cycle: the set wins.
  - Fire and a mode write in one cycle: the bus write wins (re-arm or disarm), and the status bit still sets.
  - Soft reset beats everything else in that cycle.
- Counter wrap from 2^64−1 to 0 is seamless, because the comparison uses modular subtraction.

## Timing
- Reset (rst_ni low, asynchronous) or soft reset:
  - counter, divider, prescale, irq_status, irq_enable = 0.
  - Every channel: delay = 0, mode = OFF, repeat = 0, remaining = 0, start = 0.
  - interrupt_request_o = 0.
  - The first counter increment occurs on the first clock edge after release.
- Reads: `read_data_o` reflects register state in the same cycle as `req_i`; 0-cycle latency.
- Writes take effect at the clock edge that samples `req_i & write_enable_i`.
- Fire latency:
  - The fire condition is evaluated on registered state.
  - irq_status[n] is visible one edge after the condition becomes true.
  - `interrupt_request_o` is registered-state combinational and rises in the same cycle irq_status is visible.
- Arming at counter value C with delay D fires in the cycle when counter = C+D; the status bit reads 1 from the next cycle.

## Structure
- Package `timer_pkg`:
  - Mode enum `timer_mode_e`.
  - Global address offsets.
  - Channel base 0x40 and stride 0x20.
  - Field offsets.
- Sub-module `timer_channel`, instantiated `CHANNELS` times:
  - State: delay, mode, repeat, remaining, start.
  - Outputs: a fire pulse and a read mux.
- The top level owns:
  - Prescaler and counter.
  - Address decode.
  - Status, enable and IRQ logic.

## Test plan
- Reset and counter:
  - Stimulus: pulse rst_ni low mid-cycle.
  - Response: all reads return 0 and interrupt_request_o=0. After release with prescale=0, counter lo reads N after N edges. Writing prescale=3 gives one tick per 4 clocks.
- NTIMES on channel 0:
  - Stimulus: delay=10, repeat=3, irq_enable=1, mode←1.
  - Response: exactly 3 fires, 10 ticks apart. remaining reads 2, 1, 0. Mode reads 0 after the third fire.
- FOREVER with W1C, channel 2:
  - Stimulus: delay=5, mode←2; W1C clears of bit 2 issued between fires.
  - Response: IRQ reasserts every 5 ticks.
  - Stimulus: W1C issued in the exact fire cycle. Response: the bit remains set.
- Masking and multi-channel:
  - Stimulus: channel 1 with delay=4 and channel 3 with delay=6, both FOREVER, irq_enable=0b1000.
  - Response: status shows both bits, but the IRQ follows only channel 3.
- Wrap and edges:
  - Stimulus 1: force counter near 2^64−3 via a test hook, then delay=5. Response: fires 5 ticks later across the wrap.
  - Stimulus 2: delay=0. Response: fires every tick.
  - Stimulus 3: mode write of 3. Response: ignored.
- Soft reset:
  - Stimulus: write 0x24 while channels are armed and status is pending.
  - Response: all state reads 0 and the IRQ drops on the next cycle.
